// File: rtl/multicycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_pkg
// Shared encodings for the multi-cycle RV32I control path: FSM state codes,
// RV32I major opcodes, datapath select constants and the ALU-op-signal values
// that ALUControlUnit consumes. The datapath and ALUControlUnit import this
// package, so every block agrees on the same values.
//
// Configuration macro: MCU_ECALL_HALT_EN adds the HALT state encoding.
// -----------------------------------------------------------------------------
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID    = 3'd1,
    ST_EX    = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
`ifdef MCU_ECALL_HALT_EN
    ST_PCINC = 3'd5,
    ST_HALT  = 3'd6
`else
    ST_PCINC = 3'd5
`endif
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // ALU operand B select
  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

  // ALU operand A select
  localparam logic ALU_SRC_A_PC  = 1'b0;
  localparam logic ALU_SRC_A_REG = 1'b1;

  // Next-PC select
  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  // ALU-op-signal interface towards ALUControlUnit
  localparam logic OP_SIG_ADD = 1'b0;
  localparam logic OP_SIG_ALU = 1'b1;

  typedef struct packed {
    logic       alu_op_sig;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       write_enable;
    logic       pc_write;
    logic       pc_source;
    logic       is_halted;
  } ctrl_t;

  // Opcodes that get an EX state; everything else is skipped via PCINC.
  function automatic logic opcode_has_ex(input logic [6:0] op);
    return (op == OP_RTYPE)  || (op == OP_ITYPE) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// -----------------------------------------------------------------------------
// control_output_decoder
// Purely combinational decode of the current FSM state (plus opcode,
// mem_ready and alu_bcond) into every datapath strobe and select.
// Any output not explicitly driven for a state stays 0.
//
// Ports:
//   state     in  current FSM state
//   opcode    in  IR[6:0]
//   mem_ready in  memory completes the current access this cycle
//   alu_bcond in  branch condition from the ALU
//   ctrl      out all control strobes/selects
//
// Configuration macro: MCU_ECALL_HALT_EN adds decode of the HALT state.
// -----------------------------------------------------------------------------
module control_output_decoder
  import multicycle_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_bcond,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b0;
        ctrl.ir_write = mem_ready;
      end

      // ALUOut <= PC + imm, used later as the JAL/branch target
      ST_ID: begin
        ctrl.alu_src_a  = ALU_SRC_A_PC;
        ctrl.alu_src_b  = ALU_SRC_B_IMM;
        ctrl.alu_op_sig = OP_SIG_ADD;
      end

      ST_EX: begin
        case (opcode)
          OP_RTYPE: begin
            ctrl.alu_src_a  = ALU_SRC_A_REG;
            ctrl.alu_src_b  = ALU_SRC_B_REG;
            ctrl.alu_op_sig = OP_SIG_ALU;
          end
          OP_ITYPE: begin
            ctrl.alu_src_a  = ALU_SRC_A_REG;
            ctrl.alu_src_b  = ALU_SRC_B_IMM;
            ctrl.alu_op_sig = OP_SIG_ALU;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a  = ALU_SRC_A_REG;
            ctrl.alu_src_b  = ALU_SRC_B_IMM;
            ctrl.alu_op_sig = OP_SIG_ADD;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a  = ALU_SRC_A_REG;
            ctrl.alu_src_b  = ALU_SRC_B_REG;
            ctrl.alu_op_sig = OP_SIG_ALU;
            if (alu_bcond) begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_SRC_ALUOUT;
            end
          end
          // Link value PC+4 goes to ALUOut; the jump target was latched in ID
          OP_JAL: begin
            ctrl.alu_src_a  = ALU_SRC_A_PC;
            ctrl.alu_src_b  = ALU_SRC_B_FOUR;
            ctrl.alu_op_sig = OP_SIG_ADD;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_SRC_ALUOUT;
          end
          OP_JALR: begin
            ctrl.alu_src_a  = ALU_SRC_A_PC;
            ctrl.alu_src_b  = ALU_SRC_B_FOUR;
            ctrl.alu_op_sig = OP_SIG_ADD;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (opcode == OP_LOAD);
        ctrl.mem_write = (opcode == OP_STORE);
      end

      ST_WB: begin
        ctrl.write_enable = 1'b1;
        ctrl.mem_to_reg   = (opcode == OP_LOAD);
        case (opcode)
          OP_RTYPE, OP_ITYPE, OP_LOAD: begin
            ctrl.alu_src_a  = ALU_SRC_A_PC;
            ctrl.alu_src_b  = ALU_SRC_B_FOUR;
            ctrl.alu_op_sig = OP_SIG_ADD;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_SRC_ALU;
          end
          // JALR target A+imm goes straight from the ALU into PC
          OP_JALR: begin
            ctrl.alu_src_a  = ALU_SRC_A_REG;
            ctrl.alu_src_b  = ALU_SRC_B_IMM;
            ctrl.alu_op_sig = OP_SIG_ADD;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_SRC_ALU;
          end
          default: ;
        endcase
      end

      ST_PCINC: begin
        ctrl.alu_src_a  = ALU_SRC_A_PC;
        ctrl.alu_src_b  = ALU_SRC_B_FOUR;
        ctrl.alu_op_sig = OP_SIG_ADD;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_ALU;
      end

`ifdef MCU_ECALL_HALT_EN
      ST_HALT: begin
        ctrl.is_halted = 1'b1;
      end
`endif

      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Main control FSM of the multi-cycle RV32I CPU. Holds the state register and
// next-state logic; strobes are decoded combinationally by
// control_output_decoder and forced to 0 while reset is asserted.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IF    | fetch: read mem[PC], load IR when mem_ready
//   ID    | decode: ALUOut <= PC + imm
//   EX    | execute by opcode (ALU op, address calc, branch, jump link)
//   MEM   | data access at ALUOut, held until mem_ready
//   WB    | register write-back and PC update
//   PCINC | PC <= PC + 4 for instructions without a WB-side PC update
//   HALT  | terminal, is_halted=1 (only with MCU_ECALL_HALT_EN)
//
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous active-low reset
//   opcode[6:0]  in  IR[6:0], valid from ID onward
//   mem_ready    in  memory completes current access this cycle
//   alu_bcond    in  branch condition (sampled in EX for BRANCH)
//   x17_is_10    in  x17 == 10 (sampled in ID for ECALL)
//   alu_op_sig   out 0 = forced ADD, 1 = instruction-decoded op
//   alu_src_a    out 0 = PC, 1 = register A
//   alu_src_b    out 00 = register B, 01 = 4, 10 = immediate
//   i_or_d       out memory address 0 = PC, 1 = ALUOut
//   mem_read     out memory read strobe
//   mem_write    out memory write strobe
//   ir_write     out load IR
//   mem_to_reg   out write-back data 1 = MDR, 0 = ALUOut
//   write_enable out register file write
//   pc_write     out PC update
//   pc_source    out next PC 0 = ALU result, 1 = ALUOut
//   is_halted    out sticky halt flag
//
// Configuration macro: MCU_ECALL_HALT_EN -- ECALL with x17==10 enters HALT.
// When undefined there is no HALT state and is_halted stays 0.
// -----------------------------------------------------------------------------
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_bcond,
  input  logic       x17_is_10,
  output logic       alu_op_sig,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       write_enable,
  output logic       pc_write,
  output logic       pc_source,
  output logic       is_halted
);

  state_t state;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl_out;

`ifndef MCU_ECALL_HALT_EN
  logic unused_x17;
  assign unused_x17 = x17_is_10;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IF;
    end else begin
      case (state)
        ST_IF: begin
          if (mem_ready) state <= ST_ID;
        end

        ST_ID: begin
          if (opcode == OP_ECALL) begin
`ifdef MCU_ECALL_HALT_EN
            state <= x17_is_10 ? ST_HALT : ST_PCINC;
`else
            state <= ST_PCINC;
`endif
          end else if (opcode_has_ex(opcode)) begin
            state <= ST_EX;
          end else begin
            state <= ST_PCINC;
          end
        end

        ST_EX: begin
          case (opcode)
            OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR: state <= ST_WB;
            OP_LOAD, OP_STORE:                   state <= ST_MEM;
            OP_BRANCH: state <= alu_bcond ? ST_IF : ST_PCINC;
            default:                             state <= ST_IF;
          endcase
        end

        ST_MEM: begin
          if (mem_ready) state <= (opcode == OP_LOAD) ? ST_WB : ST_PCINC;
        end

        ST_WB:    state <= ST_IF;
        ST_PCINC: state <= ST_IF;

`ifdef MCU_ECALL_HALT_EN
        ST_HALT:  state <= ST_HALT;
`endif

        default:  state <= ST_IF;
      endcase
    end
  end

  control_output_decoder u_decoder (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .alu_bcond (alu_bcond),
    .ctrl      (ctrl_dec)
  );

  // Reset gates outputs combinationally so an in-flight access (including the
  // IF fetch strobe) drops in the same cycle reset is pulled low.
  assign ctrl_out = reset ? ctrl_dec : '0;

  assign alu_op_sig   = ctrl_out.alu_op_sig;
  assign alu_src_a    = ctrl_out.alu_src_a;
  assign alu_src_b    = ctrl_out.alu_src_b;
  assign i_or_d       = ctrl_out.i_or_d;
  assign mem_read     = ctrl_out.mem_read;
  assign mem_write    = ctrl_out.mem_write;
  assign ir_write     = ctrl_out.ir_write;
  assign mem_to_reg   = ctrl_out.mem_to_reg;
  assign write_enable = ctrl_out.write_enable;
  assign pc_write     = ctrl_out.pc_write;
  assign pc_source    = ctrl_out.pc_source;
  assign is_halted    = ctrl_out.is_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Each step drives inputs on the
// falling edge, waits 1 time unit and compares the packed output vector
// against a hand-built expected pattern.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       mem_ready = 1'b1;
  logic       alu_bcond = 1'b0;
  logic       x17_is_10 = 1'b0;

  logic       alu_op_sig, alu_src_a, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, write_enable, pc_write, pc_source, is_halted;
  logic [1:0] alu_src_b;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] EC_OP  = 7'b1110011;
  localparam logic [6:0] BAD_OP = 7'b0000000;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .alu_bcond    (alu_bcond),
    .x17_is_10    (x17_is_10),
    .alu_op_sig   (alu_op_sig),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .write_enable (write_enable),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .is_halted    (is_halted)
  );

  logic [12:0] obs;
  assign obs = {alu_op_sig, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, write_enable, pc_write, pc_source, is_halted};

  // Order: op_sig, src_a, src_b, i_or_d, mem_read, mem_write, ir_write,
  //        mem_to_reg, write_enable, pc_write, pc_source, is_halted
  function automatic logic [12:0] o(input logic op, input logic a, input logic [1:0] b,
                                    input logic iord, input logic mr, input logic mw,
                                    input logic irw, input logic m2r, input logic we,
                                    input logic pcw, input logic pcs, input logic h);
    return {op, a, b, iord, mr, mw, irw, m2r, we, pcw, pcs, h};
  endfunction

  logic [12:0] E_ZERO, E_IF_WAIT, E_IF_GO, E_ID, E_EX_R, E_EX_I, E_EX_MEM;
  logic [12:0] E_EX_BR_T, E_EX_BR_N, E_EX_JAL, E_EX_JALR, E_MEM_LD, E_MEM_ST;
  logic [12:0] E_WB_RI, E_WB_LD, E_WB_JALR, E_WB_JAL, E_PCINC, E_HALT;

  task automatic chk(input string tag, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] op, input logic mr,
                     input logic bc, input logic x17, input logic [12:0] exp);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    alu_bcond = bc;
    x17_is_10 = x17;
    #1;
    chk(tag, exp);
  endtask

  initial begin
    E_ZERO    = '0;
    E_IF_WAIT = o(0,0,2'b00,0,1,0,0,0,0,0,0,0);
    E_IF_GO   = o(0,0,2'b00,0,1,0,1,0,0,0,0,0);
    E_ID      = o(0,0,2'b10,0,0,0,0,0,0,0,0,0);
    E_EX_R    = o(1,1,2'b00,0,0,0,0,0,0,0,0,0);
    E_EX_I    = o(1,1,2'b10,0,0,0,0,0,0,0,0,0);
    E_EX_MEM  = o(0,1,2'b10,0,0,0,0,0,0,0,0,0);
    E_EX_BR_T = o(1,1,2'b00,0,0,0,0,0,0,1,1,0);
    E_EX_BR_N = o(1,1,2'b00,0,0,0,0,0,0,0,0,0);
    E_EX_JAL  = o(0,0,2'b01,0,0,0,0,0,0,1,1,0);
    E_EX_JALR = o(0,0,2'b01,0,0,0,0,0,0,0,0,0);
    E_MEM_LD  = o(0,0,2'b00,1,1,0,0,0,0,0,0,0);
    E_MEM_ST  = o(0,0,2'b00,1,0,1,0,0,0,0,0,0);
    E_WB_RI   = o(0,0,2'b01,0,0,0,0,0,1,1,0,0);
    E_WB_LD   = o(0,0,2'b01,0,0,0,0,1,1,1,0,0);
    E_WB_JALR = o(0,1,2'b10,0,0,0,0,0,1,1,0,0);
    E_WB_JAL  = o(0,0,2'b00,0,0,0,0,0,1,0,0,0);
    E_PCINC   = o(0,0,2'b01,0,0,0,0,0,0,1,0,0);
    E_HALT    = o(0,0,2'b00,0,0,0,0,0,0,0,0,1);

    // Reset held: every output 0, including the fetch strobe
    cyc("rst_hold", R_OP, 1, 0, 0, E_ZERO);
    reset = 1'b1;
    mem_ready = 1'b0;
    cyc("if_first_wait", R_OP, 0, 0, 0, E_IF_WAIT);

    // ADD: IF ID EX WB
    cyc("add_if", R_OP, 1, 0, 0, E_IF_GO);
    cyc("add_id", R_OP, 1, 0, 0, E_ID);
    cyc("add_ex", R_OP, 1, 0, 0, E_EX_R);
    cyc("add_wb", R_OP, 1, 0, 0, E_WB_RI);

    // ADDI with mem_ready low outside IF: must not stall
    cyc("addi_if", I_OP, 1, 0, 0, E_IF_GO);
    cyc("addi_id", I_OP, 0, 1, 0, E_ID);
    cyc("addi_ex", I_OP, 0, 1, 0, E_EX_I);
    cyc("addi_wb", I_OP, 0, 1, 0, E_WB_RI);

    // LOAD with 3 MEM wait cycles, 8 cycles total
    cyc("ld_if", LD_OP, 1, 0, 0, E_IF_GO);
    cyc("ld_id", LD_OP, 1, 0, 0, E_ID);
    cyc("ld_ex", LD_OP, 1, 0, 0, E_EX_MEM);
    cyc("ld_mem_w1", LD_OP, 0, 0, 0, E_MEM_LD);
    cyc("ld_mem_w2", LD_OP, 0, 0, 0, E_MEM_LD);
    cyc("ld_mem_w3", LD_OP, 0, 0, 0, E_MEM_LD);
    cyc("ld_mem_go", LD_OP, 1, 0, 0, E_MEM_LD);
    cyc("ld_wb", LD_OP, 1, 0, 0, E_WB_LD);

    // STORE: IF ID EX MEM PCINC
    cyc("st_if", ST_OP, 1, 0, 0, E_IF_GO);
    cyc("st_id", ST_OP, 1, 0, 0, E_ID);
    cyc("st_ex", ST_OP, 1, 0, 0, E_EX_MEM);
    cyc("st_mem", ST_OP, 1, 0, 0, E_MEM_ST);
    cyc("st_pcinc", ST_OP, 1, 0, 0, E_PCINC);

    // Taken branch: IF ID EX
    cyc("beq_t_if", BR_OP, 1, 0, 0, E_IF_GO);
    cyc("beq_t_id", BR_OP, 1, 0, 0, E_ID);
    cyc("beq_t_ex", BR_OP, 1, 1, 0, E_EX_BR_T);

    // Not-taken branch: IF ID EX PCINC (with fetch stall first)
    cyc("beq_n_if_wait", BR_OP, 0, 0, 0, E_IF_WAIT);
    cyc("beq_n_if", BR_OP, 1, 0, 0, E_IF_GO);
    cyc("beq_n_id", BR_OP, 1, 1, 0, E_ID);
    cyc("beq_n_ex", BR_OP, 1, 0, 0, E_EX_BR_N);
    cyc("beq_n_pcinc", BR_OP, 1, 0, 0, E_PCINC);

    // JAL
    cyc("jal_if", JAL_OP, 1, 0, 0, E_IF_GO);
    cyc("jal_id", JAL_OP, 1, 0, 0, E_ID);
    cyc("jal_ex", JAL_OP, 1, 0, 0, E_EX_JAL);
    cyc("jal_wb", JAL_OP, 1, 0, 0, E_WB_JAL);

    // JALR
    cyc("jalr_if", JR_OP, 1, 0, 0, E_IF_GO);
    cyc("jalr_id", JR_OP, 1, 0, 0, E_ID);
    cyc("jalr_ex", JR_OP, 1, 0, 0, E_EX_JALR);
    cyc("jalr_wb", JR_OP, 1, 0, 0, E_WB_JALR);

    // Unknown opcode skips EX
    cyc("bad_if", BAD_OP, 1, 0, 0, E_IF_GO);
    cyc("bad_id", BAD_OP, 1, 0, 0, E_ID);
    cyc("bad_pcinc", BAD_OP, 1, 0, 0, E_PCINC);

    // Non-halting ECALL
    cyc("ecall_if", EC_OP, 1, 0, 0, E_IF_GO);
    cyc("ecall_id", EC_OP, 1, 0, 0, E_ID);
    cyc("ecall_pcinc", EC_OP, 1, 0, 0, E_PCINC);

    // STORE interrupted by reset in MEM
    cyc("strst_if", ST_OP, 1, 0, 0, E_IF_GO);
    cyc("strst_id", ST_OP, 1, 0, 0, E_ID);
    cyc("strst_ex", ST_OP, 1, 0, 0, E_EX_MEM);
    cyc("strst_mem", ST_OP, 0, 0, 0, E_MEM_ST);
    #2;
    reset = 1'b0;
    #1;
    chk("strst_drop", E_ZERO);
    cyc("strst_hold", ST_OP, 1, 0, 0, E_ZERO);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("strst_release", E_IF_WAIT);

    // ECALL with x17 == 10
    cyc("halt_if", EC_OP, 1, 0, 0, E_IF_GO);
    cyc("halt_id", EC_OP, 1, 0, 1, E_ID);
`ifdef MCU_ECALL_HALT_EN
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("halt_hold_%0d", i), (i % 2 == 0) ? R_OP : LD_OP,
          1'(i % 2), 1'(i % 3 == 0), 1'b1, E_HALT);
    end
`else
    cyc("halt_off_pcinc", EC_OP, 1, 0, 1, E_PCINC);
    cyc("halt_off_if", EC_OP, 0, 0, 1, E_IF_WAIT);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main control FSM of the multi-cycle RV32I CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states. Every cycle it drives the datapath select and enable signals and `alu_op_sig`. `alu_op_sig` is the producer side of the ALU-op-signal interface: `ALUControlUnit` consumes it to choose between a forced ADD (`0`) and an instruction-decoded operation (`1`).

## Interface
Parameters:
- none; all encodings are fixed constants in the shared header.

Ports:
- `clk` input 1 system clock; all state changes on the rising edge.
- `reset` input 1 asynchronous, active-low reset; `reset==0` holds the block in reset.
- `opcode` input 7 `IR[6:0]`; valid from ID onward.
- `mem_ready` input 1 memory completes the current access this cycle.
- `alu_bcond` input 1 branch condition from the ALU; sampled only in EX for BRANCH.
- `x17_is_10` input 1 register x17 equals 10; sampled only in ID for ECALL.
- `alu_op_sig` output 1 `0` forces ADD; `1` selects instruction-decoded ALU operation.
- `alu_src_a` output 1 `0`=PC, `1`=register A.
- `alu_src_b` output 2 `00`=register B, `01`=constant 4, `10`=immediate.
- `i_or_d` output 1 memory address: `0`=PC, `1`=ALUOut.
- `mem_read` / `mem_write` output 1 each; memory access strobes.
- `ir_write` output 1 load IR.
- `mem_to_reg` output 1 write-back data: `1`=MDR, `0`=ALUOut.
- `write_enable` output 1 register file write.
- `pc_write` output 1 PC update.
- `pc_source` output 1 next PC: `0`=ALU result, `1`=ALUOut.
- `is_halted` output 1 sticky halt flag.

## Operation
- States: IF, ID, EX, MEM, WB, PCINC, HALT.
- Outputs are combinational from state plus `mem_ready`/`alu_bcond`. Any output not listed for a state is 0.
- IF: `mem_read=1`, `i_or_d=0`.
  - Holds while `mem_ready=0`.
  - When `mem_ready=1`: `ir_write=1`, then go to ID.
- ID: `alu_src_a=0`, `alu_src_b=10`, `alu_op_sig=0`, so ALUOut gets PC+imm.
  - ECALL or unknown opcode: go to PCINC.
  - All other opcodes: go to EX.
- EX, by opcode:
  - R-type: A op B, `alu_op_sig=1`; go to WB.
  - I-type arithmetic: A op imm, `alu_op_sig=1`; go to WB.
  - LOAD/STORE: A+imm, `alu_op_sig=0`; go to MEM.
  - BRANCH: A,B, `alu_op_sig=1`.
    - `alu_bcond=1`: `pc_write=1`, `pc_source=1`; go to IF.
    - `alu_bcond=0`: go to PCINC.
  - JAL: PC+4 into ALUOut; `pc_write=1`, `pc_source=1` (target computed in ID); go to WB.
  - JALR: PC+4 into ALUOut; go to WB.
- MEM: `i_or_d=1`, with `mem_read` (LOAD) or `mem_write` (STORE).
  - Holds the strobe until `mem_ready=1`.
  - LOAD then goes to WB; STORE goes to PCINC.
- WB: `write_enable=1`; `mem_to_reg=1` for LOAD only.
  - R-type, I-type, LOAD: ALU computes PC+4 (`alu_src_a=0`, `alu_src_b=01`, ADD), `pc_write=1`, `pc_source=0`.
  - JALR: ALU computes A+imm (ADD), `pc_write=1`, `pc_source=0`.
  - JAL: no PC write.
  - All cases then go to IF.
- PCINC: PC+4 through the ALU, `pc_write=1`, `pc_source=0`; go to IF.
- HALT: all strobes 0, `is_halted=1`; terminal until reset.
- `mem_ready` is ignored outside IF and MEM.

## Timing
- Reset assertion is asynchronous: state goes to IF and every output is 0 while `reset==0`, including `mem_read`. `is_halted` clears.
- First cycle after reset release: IF with `mem_read=1`.
- Latency with `mem_ready` tied high:
  - R-type, I-type, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 5 cycles.
  - Taken branch: 3 cycles.
  - Not-taken branch: 4 cycles.
  - ECALL (non-halting): 3 cycles.
- Each cycle of `mem_ready=0` in IF or MEM adds one cycle.
- Reset during MEM or IF abandons the access; strobes drop immediately.

## Configuration
- `MCU_ECALL_HALT_EN` defined: ECALL with `x17_is_10=1` sampled in ID moves to HALT. `is_halted` rises the next cycle and stays high.
- Not defined: there is no HALT state, `is_halted` is tied 0, and every ECALL follows ID → PCINC.

## Structure
- State encodings, the `alu_src_b`/`pc_source` select constants and the `OP_SIG_ADD`/`OP_SIG_ALU` values live in a shared header next to `opcodes.v`, so `ALUControlUnit` and the datapath use the same definitions. Opcodes come from `opcodes.v`.
- One sub-module, `control_output_decoder`: combinational (state, opcode, `mem_ready`, `alu_bcond`) → all strobes. The top level holds the state register and next-state logic.

## Test plan
- ADD (`0110011`), `mem_ready=1`: IF, ID, EX, WB, IF. EX shows `alu_op_sig=1`, `alu_src_a=1`, `alu_src_b=00`. WB shows `write_enable=1`, `pc_write=1`, `pc_source=0`.
- LOAD with `mem_ready=0` for 3 MEM cycles: `mem_read=1` and `i_or_d=1` held for 4 cycles. Then WB with `mem_to_reg=1`, 8 cycles total.
- BEQ: `alu_bcond=1` gives `pc_write=1`, `pc_source=1` in EX, then IF. `alu_bcond=0` gives EX, PCINC (`pc_write=1`, `pc_source=0`), then IF.
- JAL: EX shows `pc_write=1`, `pc_source=1`; WB shows `write_enable=1` with `pc_write=0`. JALR: EX shows `pc_write=0`; WB shows `pc_write=1`, `pc_source=0`.
- ECALL, `x17_is_10=1`:
  - Macro on: `is_halted=1` from the cycle after ID, all strobes 0 for 20 cycles.
  - Macro off: PCINC then IF.
- Reset pulled low mid-MEM during a STORE: `mem_write` drops to 0 in the same cycle. After release, IF with `mem_read=1` and `is_halted=0`.
